// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle RV32I controller: opcodes, FSM states,
// trap causes, datapath mux encodings and the ALU operation decoder.
package multicycle_control_unit_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_OP_IMM = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_UPPER, S_TRAP, S_HALT
  } mc_state_t;

  typedef enum logic [1:0] {
    TC_ECALL = 2'd0, TC_EBREAK = 2'd1, TC_ILLEGAL = 2'd2, TC_BUS = 2'd3
  } trap_cause_t;

  localparam logic [1:0] SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RS1 = 2'd2;
  localparam logic [1:0] SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2;
  localparam logic [1:0] RES_ALUOUT = 2'd0, RES_MEMDATA = 2'd1, RES_ALU = 2'd2;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
                         ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
                         ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_PASSB = 5'd10;

  localparam logic [1:0] ALUM_R = 2'd0, ALUM_I = 2'd1, ALUM_BR = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [4:0] alu_control;
    logic       trap;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Branches only need a compare, so SUB for (in)equality and SLT/SLTU for ordering.
  function automatic logic [4:0] alu_decode(input logic [1:0] mode, input logic [2:0] f3,
                                            input logic f7);
    logic [4:0] op;
    op = ALU_ADD;
    if (mode == ALUM_BR) begin
      case (f3)
        3'b100, 3'b101: op = ALU_SLT;
        3'b110, 3'b111: op = ALU_SLTU;
        default:        op = ALU_SUB;
      endcase
    end else begin
      case (f3)
        3'b000:  op = (mode == ALUM_R && f7) ? ALU_SUB : ALU_ADD;
        3'b001:  op = ALU_SLL;
        3'b010:  op = ALU_SLT;
        3'b011:  op = ALU_SLTU;
        3'b100:  op = ALU_XOR;
        3'b101:  op = f7 ? ALU_SRA : ALU_SRL;
        3'b110:  op = ALU_OR;
        3'b111:  op = ALU_AND;
        default: op = ALU_ADD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_branch_eval.sv
// Branch condition evaluator: funct3 plus ALU flags -> taken.
module branch_eval
  import multicycle_control_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  output logic       taken
);

  // Decode funct3 against the ALU zero / less-than flags
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = zero;
      3'b001:         taken = ~zero;
      3'b100, 3'b110: taken = lt;
      3'b101, 3'b111: taken = ~lt;
      default:        taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I controller with memory handshake, bus timeout and trap/halt.
// Datapath controls are registered from the next state; fetch/branch PC enables are Mealy.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT    = 16,
  parameter bit HALT_ON_EBREAK = 1'b1,
  parameter int CNT_W          = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7,
  input  logic [11:0] funct12,
  input  logic        ZeroFlag,
  input  logic        LessThanFlag,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  SrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ImmSrc,
  output logic [4:0]  ALUControl,
  output logic        Trap,
  output logic [1:0]  TrapCause,
  output logic        Halted
);

  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  mc_state_t   state_r, state_n_s;
  trap_cause_t cause_r, cause_n_s;
  ctrl_t       ctrl_r;
  logic [CW-1:0] cnt_r;
  logic taken_s, mem_done_s, mem_wait_s, timeout_s, irwrite_s;

  branch_eval u_branch_eval (
    .funct3 (funct3),
    .zero   (ZeroFlag),
    .lt     (LessThanFlag),
    .taken  (taken_s)
  );

  // A handshake only counts while our registered request is up
  assign mem_done_s = ctrl_r.mem_req & MemReady;
  assign mem_wait_s = ctrl_r.mem_req & ~MemReady;
  assign timeout_s  = (MEM_TIMEOUT != 0) && mem_wait_s && (cnt_r == TO_LAST);

  function automatic ctrl_t decode_ctrl(input mc_state_t st, input logic [6:0] op,
                                        input logic [2:0] f3, input logic f7);
    ctrl_t c;
    c = CTRL_IDLE;
    case (st)
      S_FETCH:  begin c.mem_req = 1'b1; c.src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALU; end
      S_DECODE: begin c.src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_B; end
      S_MEMADR: begin
        c.src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM;
        c.imm_src = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMRD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.result_src = RES_MEMDATA; end
      S_MEMWR:  begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; end
      S_EXECR:  begin c.src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_control = alu_decode(ALUM_R, f3, f7); end
      S_EXECI:  begin
        c.src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_I;
        c.alu_control = alu_decode(ALUM_I, f3, f7);
      end
      S_UPPER:  begin
        c.src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_U;
        c.alu_control = (op == OP_LUI) ? ALU_PASSB : ALU_ADD;
      end
      S_BRANCH: begin c.src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_control = alu_decode(ALUM_BR, f3, f7); end
      S_JAL:    begin c.pc_write = 1'b1; c.src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_J; c.result_src = RES_ALU; end
      S_JALR:   begin c.pc_write = 1'b1; c.src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_I; c.result_src = RES_ALU; end
      S_ALUWB:  begin
        // Jumps write the link value OldPC+4 straight from the ALU
        c.reg_write = 1'b1; c.src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR;
        c.result_src = (op == OP_JAL || op == OP_JALR) ? RES_ALU : RES_ALUOUT;
      end
      S_TRAP:   c.trap = 1'b1;
      S_HALT:   c.halted = 1'b1;
      default:  c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  // Next-state and trap-cause selection
  always_comb begin
    state_n_s = state_r;
    cause_n_s = cause_r;
    case (state_r)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_done_s) begin
          if (state_r == S_FETCH)      state_n_s = S_DECODE;
          else if (state_r == S_MEMRD) state_n_s = S_MEMWB;
          else                         state_n_s = S_FETCH;
        end else if (timeout_s) begin
          state_n_s = S_TRAP;
          cause_n_s = TC_BUS;
        end else begin
          state_n_s = state_r;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE:  state_n_s = S_MEMADR;
          OP_OP:              state_n_s = S_EXECR;
          OP_OP_IMM:          state_n_s = S_EXECI;
          OP_BRANCH:          state_n_s = S_BRANCH;
          OP_JAL:             state_n_s = S_JAL;
          OP_JALR:            state_n_s = S_JALR;
          OP_LUI, OP_AUIPC:   state_n_s = S_UPPER;
          OP_FENCE:           state_n_s = S_FETCH;
          OP_SYSTEM: begin
            if (funct3 == 3'd0 && funct12 == 12'd0) begin
              state_n_s = S_TRAP;
              cause_n_s = TC_ECALL;
            end else if (funct3 == 3'd0 && funct12 == 12'd1) begin
              if (HALT_ON_EBREAK) begin
                state_n_s = S_HALT;
              end else begin
                state_n_s = S_TRAP;
                cause_n_s = TC_EBREAK;
              end
            end else begin
              state_n_s = S_TRAP;
              cause_n_s = TC_ILLEGAL;
            end
          end
          default: begin
            state_n_s = S_TRAP;
            cause_n_s = TC_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_n_s = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_EXECR, S_EXECI, S_UPPER, S_JAL, S_JALR: state_n_s = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_TRAP:       state_n_s = S_FETCH;
      S_HALT:   state_n_s = S_HALT;
      default:  state_n_s = S_FETCH;
    endcase
  end

  // State, wait counter, trap cause and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
      cause_r <= TC_ECALL;
      cnt_r   <= '0;
      ctrl_r  <= CTRL_IDLE;
    end else begin
      state_r <= state_n_s;
      cause_r <= cause_n_s;
      ctrl_r  <= decode_ctrl(state_n_s, opcode, funct3, funct7);
      if (state_n_s != state_r) cnt_r <= '0;
      else if (mem_wait_s)      cnt_r <= cnt_r + CW'(1);
      else                      cnt_r <= cnt_r;
    end
  end

  assign irwrite_s  = (state_r == S_FETCH) & mem_done_s;
  assign IRWrite    = irwrite_s;
  assign PCWrite    = irwrite_s | ctrl_r.pc_write | ((state_r == S_BRANCH) & taken_s);
  assign MemReq     = ctrl_r.mem_req;
  assign MemWrite   = ctrl_r.mem_write;
  assign AdrSrc     = ctrl_r.adr_src;
  assign RegWrite   = ctrl_r.reg_write;
  assign SrcA       = ctrl_r.src_a;
  assign ALUSrcB    = ctrl_r.alu_src_b;
  assign ResultSrc  = ctrl_r.result_src;
  assign ImmSrc     = ctrl_r.imm_src;
  assign ALUControl = ctrl_r.alu_control;
  assign Trap       = ctrl_r.trap;
  assign TrapCause  = cause_r;
  assign Halted     = ctrl_r.halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised bench for multicycle_control_unit: a per-instruction trace model
// predicts each cycle's control outputs from the instruction class and wait counts.
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  localparam int TO = 4;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011, RI = 7'b0010011,
                         BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111,
                         AU = 7'b0010111, FN = 7'b0001111, SY = 7'b1110011;

  logic clk = 1'b0;
  logic reset, funct7, ZeroFlag, LessThanFlag, MemReady;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [11:0] funct12;
  logic MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Trap, Halted;
  logic [1:0] SrcA, ALUSrcB, ResultSrc, TrapCause;
  logic [2:0] ImmSrc;
  logic [4:0] ALUControl;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_TIMEOUT(TO), .HALT_ON_EBREAK(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .funct12(funct12), .ZeroFlag(ZeroFlag), .LessThanFlag(LessThanFlag), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .SrcA(SrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .Trap(Trap), .TrapCause(TrapCause), .Halted(Halted)
  );

  typedef struct packed {
    logic req, wr, adr, irw, pcw, rw;
    logic [1:0] res;
    logic [4:0] alu;
    logic trap;
    logic [1:0] cause;
    logic halted;
  } obs_t;

  typedef struct {
    logic rdy; logic [6:0] op; logic [2:0] f3; logic f7; logic [11:0] f12; logic z, lt;
    obs_t exp;
  } step_t;

  step_t tr_q[$];
  obs_t  obs_q[$];
  int total = 0, bad = 0;
  logic [1:0] m_cause = 2'd0;
  logic m_halt = 1'b0;
  logic [6:0] i_op; logic [2:0] i_f3; logic i_f7; logic [11:0] i_f12; logic i_z, i_lt;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t blank();
    obs_t e;
    e = '0; e.cause = m_cause; e.halted = m_halt;
    return e;
  endfunction

  function automatic obs_t sample();
    return {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUControl,
            Trap, TrapCause, Halted};
  endfunction

  task automatic push(input logic rdy, input obs_t e);
    step_t s;
    s.rdy = rdy; s.op = i_op; s.f3 = i_f3; s.f7 = i_f7; s.f12 = i_f12;
    s.z = i_z; s.lt = i_lt; s.exp = e;
    tr_q.push_back(s);
  endtask

  // One memory access: 'waits' not-ready cycles, then ready, or a bus trap if it runs out
  task automatic mem_phase(input int waits, input logic wr, input logic adr, input logic fetch,
                           output logic ok);
    obs_t e;
    e = blank(); e.req = 1'b1; e.wr = wr; e.adr = adr; e.res = fetch ? 2'd2 : 2'd0;
    if (waits >= TO) begin
      repeat (TO) push(1'b0, e);
      m_cause = 2'd3;
      e = blank(); e.trap = 1'b1;
      push(rnd(), e);
      ok = 1'b0;
    end else begin
      repeat (waits) push(1'b0, e);
      e.irw = fetch; e.pcw = fetch;
      push(1'b1, e);
      ok = 1'b1;
    end
  endtask

  task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [11:0] f12, input logic z, input logic lt,
                           input int wf, input int wm);
    obs_t e;
    logic ok;
    logic [4:0] tbl [8];
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    i_op = op; i_f3 = f3; i_f7 = f7; i_f12 = f12; i_z = z; i_lt = lt;
    mem_phase(wf, 1'b0, 1'b0, 1'b1, ok);
    if (!ok) return;
    push(rnd(), blank());
    e = blank();
    case (op)
      LD: begin
        push(rnd(), e);
        mem_phase(wm, 1'b0, 1'b1, 1'b0, ok);
        if (ok) begin e = blank(); e.rw = 1'b1; e.res = 2'd1; push(rnd(), e); end
      end
      ST: begin
        push(rnd(), e);
        mem_phase(wm, 1'b1, 1'b1, 1'b0, ok);
      end
      RR, RI: begin
        e.alu = tbl[f3];
        if (f3 == 3'd0 && op == RR && f7) e.alu = ALU_SUB;
        if (f3 == 3'd5 && f7) e.alu = ALU_SRA;
        push(rnd(), e);
        e = blank(); e.rw = 1'b1; push(rnd(), e);
      end
      BR: begin
        e.alu = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        case (f3)
          3'd0: e.pcw = z;
          3'd1: e.pcw = !z;
          3'd4, 3'd6: e.pcw = lt;
          3'd5, 3'd7: e.pcw = !lt;
          default: e.pcw = 1'b0;
        endcase
        push(rnd(), e);
      end
      JL, JR: begin
        e.pcw = 1'b1; e.res = 2'd2; push(rnd(), e);
        e = blank(); e.rw = 1'b1; e.res = 2'd2; push(rnd(), e);
      end
      LU, AU: begin
        e.alu = (op == LU) ? ALU_PASSB : ALU_ADD;
        push(rnd(), e);
        e = blank(); e.rw = 1'b1; push(rnd(), e);
      end
      FN: ;
      SY: begin
        if (f3 == 3'd0 && f12 == 12'd1) begin
          m_halt = 1'b1;
          repeat (3) push(rnd(), blank());
        end else begin
          m_cause = (f3 == 3'd0 && f12 == 12'd0) ? 2'd0 : 2'd2;
          e = blank(); e.trap = 1'b1; push(rnd(), e);
        end
      end
      default: begin
        m_cause = 2'd2;
        e = blank(); e.trap = 1'b1; push(rnd(), e);
      end
    endcase
  endtask

  task automatic play();
    obs_q.delete();
    foreach (tr_q[i]) begin
      @(negedge clk);
      MemReady = tr_q[i].rdy; opcode = tr_q[i].op; funct3 = tr_q[i].f3; funct7 = tr_q[i].f7;
      funct12 = tr_q[i].f12; ZeroFlag = tr_q[i].z; LessThanFlag = tr_q[i].lt;
      #1 obs_q.push_back(sample());
    end
  endtask

  task automatic do_reset(output obs_t o);
    @(negedge clk);
    reset = 1'b1; MemReady = rnd();
    @(negedge clk);
    #1 o = sample();
    reset = 1'b0; MemReady = 1'b1;
    m_cause = 2'd0; m_halt = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    do_reset(o);
    total++;
    if (o !== obs_t'(0)) begin bad++; $display("FAIL reset_state got %h expected %h", o, obs_t'(0)); end
  endtask

  task automatic test_add();
    gen_instr(RR, 3'd0, 1'b0, 12'd0, rnd(), rnd(), 0, 0);
    gen_instr(RR, 3'd0, 1'b1, 12'd0, rnd(), rnd(), 0, 0);
    gen_instr(RI, 3'd5, 1'b1, 12'd0, rnd(), rnd(), 1, 0);
    play();
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== tr_q[i].exp) begin bad++; $display("FAIL add cycle %0d got %h expected %h", i, obs_q[i], tr_q[i].exp); end
    end
    tr_q.delete();
  endtask

  task automatic test_load();
    int irw_cnt, rw_idx;
    gen_instr(LD, 3'd2, 1'b0, 12'd0, rnd(), rnd(), 3, 3);
    play();
    irw_cnt = 0; rw_idx = -1;
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== tr_q[i].exp) begin bad++; $display("FAIL load cycle %0d got %h expected %h", i, obs_q[i], tr_q[i].exp); end
      if (obs_q[i].irw) irw_cnt++;
      if (obs_q[i].rw && rw_idx < 0) rw_idx = i;
    end
    total++;
    if (irw_cnt != 1) begin bad++; $display("FAIL load_irwrite_count got %0d expected 1", irw_cnt); end
    total++;
    if (rw_idx != 10) begin bad++; $display("FAIL load_writeback_cycle got %0d expected 10", rw_idx); end
    tr_q.delete();
  endtask

  task automatic test_branch();
    gen_instr(BR, 3'd0, 1'b0, 12'd0, 1'b1, rnd(), 0, 0);
    gen_instr(BR, 3'd6, 1'b0, 12'd0, rnd(), 1'b0, 0, 0);
    gen_instr(BR, 3'd2, 1'b0, 12'd0, 1'b1, 1'b1, 0, 0);
    gen_instr(BR, 3'd3, 1'b0, 12'd0, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 8; k++) gen_instr(BR, 3'(k), 1'b0, 12'd0, rnd(), rnd(), 0, 0);
    play();
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== tr_q[i].exp) begin bad++; $display("FAIL branch cycle %0d got %h expected %h", i, obs_q[i], tr_q[i].exp); end
    end
    tr_q.delete();
  endtask

  task automatic test_timeout();
    gen_instr(RR, 3'd0, 1'b0, 12'd0, 1'b0, 1'b0, TO, 0);
    gen_instr(RR, 3'd7, 1'b0, 12'd0, 1'b0, 1'b0, TO - 1, 0);
    gen_instr(LD, 3'd2, 1'b0, 12'd0, 1'b0, 1'b0, 0, TO + 2);
    gen_instr(ST, 3'd2, 1'b0, 12'd0, 1'b0, 1'b0, 2, TO - 1);
    gen_instr(ST, 3'd2, 1'b0, 12'd0, 1'b0, 1'b0, 0, TO);
    play();
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== tr_q[i].exp) begin bad++; $display("FAIL timeout cycle %0d got %h expected %h", i, obs_q[i], tr_q[i].exp); end
    end
    tr_q.delete();
  endtask

  task automatic test_trap_halt();
    obs_t o;
    gen_instr(SY, 3'd0, 1'b0, 12'd0, 1'b0, 1'b0, 0, 0);
    gen_instr(7'b1111111, 3'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1, 0);
    gen_instr(SY, 3'd0, 1'b0, 12'd0, 1'b0, 1'b0, 0, 0);
    gen_instr(SY, 3'd1, 1'b0, 12'd0, 1'b0, 1'b0, 0, 0);
    gen_instr(SY, 3'd0, 1'b0, 12'd1, 1'b0, 1'b0, 0, 0);
    play();
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== tr_q[i].exp) begin bad++; $display("FAIL trap_halt cycle %0d got %h expected %h", i, obs_q[i], tr_q[i].exp); end
    end
    tr_q.delete();
    do_reset(o);
    total++;
    if (o !== obs_t'(0)) begin bad++; $display("FAIL halt_cleared got %h expected %h", o, obs_t'(0)); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    gen_instr(ST, 3'd2, 1'b0, 12'd0, 1'b0, 1'b0, 0, TO + 3);
    while (tr_q.size() > 5) void'(tr_q.pop_back());
    play();
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== tr_q[i].exp) begin bad++; $display("FAIL reset_mid cycle %0d got %h expected %h", i, obs_q[i], tr_q[i].exp); end
    end
    tr_q.delete();
    do_reset(o);
    total++;
    if (o !== obs_t'(0)) begin bad++; $display("FAIL reset_mid_abandon got %h expected %h", o, obs_t'(0)); end
    gen_instr(RR, 3'd4, 1'b0, 12'd0, 1'b0, 1'b0, 0, 0);
    play();
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== tr_q[i].exp) begin bad++; $display("FAIL reset_mid_refetch cycle %0d got %h expected %h", i, obs_q[i], tr_q[i].exp); end
    end
    tr_q.delete();
  endtask

  task automatic test_random();
    logic [6:0] ops [13];
    logic [6:0] op;
    logic [2:0] f3;
    logic [11:0] f12;
    ops = '{LD, ST, RR, RI, BR, JL, JR, LU, AU, FN, SY, 7'b1111111, 7'b0000000};
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 12)];
      f3 = 3'($urandom);
      f12 = 12'($urandom_range(0, 2));
      if (op == SY && f3 == 3'd0 && f12 == 12'd1) f12 = 12'h302;
      gen_instr(op, f3, rnd(), f12, rnd(), rnd(), $urandom_range(0, 5), $urandom_range(0, 5));
    end
    play();
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== tr_q[i].exp) begin bad++; $display("FAIL random cycle %0d got %h expected %h", i, obs_q[i], tr_q[i].exp); end
    end
    tr_q.delete();
  endtask

  initial begin
    reset = 1'b1; MemReady = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 1'b0;
    funct12 = 12'd0; ZeroFlag = 1'b0; LessThanFlag = 1'b0;
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_timeout();
    test_trap_halt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
